sm_addsub_bcd: RTL
==================

Name: sm_addsub_bcd

Overview:
- Sequential sign-magnitude add/subtract unit with parametrised operand width.
- Computes X + Y or X - Y on sign-magnitude operands, then converts the result magnitude to packed BCD with a multi-cycle shift-add-3 (double-dabble) engine.
- Drives the 7-segment digit path through registered outputs, with a start/busy/done handshake.

Parameters:
- W, 8: operand magnitude width in bits. Result magnitude width is W+1.
- NDIG, 3: number of BCD output digits. Must satisfy 10^NDIG > 2^(W+1)-1.
- CW, 4: width of the conversion step counter. Must satisfy 2^CW > W+1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = X+Y, 1 = X-Y
- sign_x  in  1  sign of X (1 = negative)
- mag_x  in  W  magnitude of X
- sign_y  in  1  sign of Y (1 = negative)
- mag_y  in  W  magnitude of Y
- busy  out  1  high in CALC and CONV
- done  out  1  one-cycle pulse when results update
- sign_out  out  1  result sign (1 = negative)
- mag_out  out  W+1  binary result magnitude
- bcd_out  out  4*NDIG  packed BCD of mag_out; digit 0 is in bits [3:0]

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, sign_out=0, mag_out=0, bcd_out=0; internal registers cleared. An in-flight operation is discarded.
- FSM states: IDLE, CALC, CONV.
- IDLE, start=1 at an edge: latch sign_x, mag_x, effective Y sign (sign_y XOR op), and mag_y. Go to CALC. busy=1 from the next cycle.
- CALC (1 cycle), with sy = effective Y sign:
  - sign_x == sy: mag = mag_x + mag_y (W+1 bits, no overflow possible); sign = sign_x.
  - Otherwise, mag_x > mag_y: mag = mag_x - mag_y; sign = sign_x.
  - Otherwise, mag_y > mag_x: mag = mag_y - mag_x; sign = sy.
  - Equal magnitudes with opposite signs: mag = 0; sign forced to 0 (no negative zero).
  - mag == 0 from any path also forces sign = 0.
  - Load the shift register with mag, clear the BCD scratch, set step counter = W+1, go to CONV.
- CONV (exactly W+1 cycles). Each cycle:
  - Every scratch digit >= 5 gets +3.
  - Shift {scratch, binary} left by 1.
  - Decrement the counter.
- On the step where the counter reaches 0: register sign_out, mag_out, bcd_out; pulse done=1 for one cycle; busy=0; return to IDLE.
- Latency: start sampled at edge t gives done=1 and new outputs in the cycle after edge t+W+2 (W+3 edges total; 11 for W=8).
- Outputs hold their last values until the next done. They never change mid-operation.
- start while busy=1: ignored. It is not queued and does not disturb the latched operands.
- start high continuously: a new operation begins at the first edge back in IDLE, i.e. the cycle done is high. Back-to-back throughput is one result per W+3 cycles.
- Input operands may change freely after the start edge.

Test Plan (W=8, NDIG=3):
- Add, same sign: +200 + +100, op=0 -> done after 11 edges; sign_out=0, mag_out=300, bcd_out=0x300.
- Opposite signs via sign_y: +5 + (-9), op=0 -> sign_out=1, mag_out=4, bcd_out=0x004.
- Zero result: (-7) - (-7), op=1 -> sign_out=0, mag_out=0, bcd_out=0x000 (no negative zero).
- Maximum: (-255) - (+255), op=1 -> sign_out=1, mag_out=510, bcd_out=0x510.
- Start while busy: start (+1)+(+1); pulse start with 99+99 at cycle 4 -> single done with 0x002; busy and done timing unchanged.
- Reset mid-conversion: assert reset at cycle 6 -> outputs immediately 0, busy=0, no done. A new start of +12 - +30 yields sign_out=1, bcd_out=0x018.

Source files
------------

// File: rtl/sm_addsub_bcd_if.sv
// Operand/result bundle for the sign-magnitude add/sub + BCD unit.
// master drives operands and start; slave returns busy/done and the registered results.
interface sm_addsub_bcd_if #(
  parameter int W    = 8,
  parameter int NDIG = 3
);
  logic              start;
  logic              op;
  logic              sign_x;
  logic [W-1:0]      mag_x;
  logic              sign_y;
  logic [W-1:0]      mag_y;
  logic              busy;
  logic              done;
  logic              sign_out;
  logic [W:0]        mag_out;
  logic [4*NDIG-1:0] bcd_out;

  modport master (
    output start, op, sign_x, mag_x, sign_y, mag_y,
    input  busy, done, sign_out, mag_out, bcd_out
  );

  modport slave (
    input  start, op, sign_x, mag_x, sign_y, mag_y,
    output busy, done, sign_out, mag_out, bcd_out
  );
endinterface

// File: rtl/sm_addsub_bcd.sv
// Sign-magnitude X+/-Y, then double-dabble to packed BCD; done pulses W+3 edges after start.
// No backpressure: start is taken only in IDLE, ignored while busy; outputs hold until next done.
module sm_addsub_bcd #(
  parameter int W    = 8,
  parameter int NDIG = 3,
  parameter int CW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  sm_addsub_bcd_if.slave   bus
);
  localparam int BW = 4 * NDIG;

  typedef enum logic [1:0] {IDLE, CALC, CONV} state_t;

  state_t          state, stateNext;
  logic            sx, sy;
  logic [W-1:0]    mx, my;
  logic [W:0]      bin, resMag;
  logic            resSign;
  logic [BW-1:0]   scr;
  logic [CW-1:0]   cnt;
  logic            doneReg, signReg;
  logic [W:0]      magReg;
  logic [BW-1:0]   bcdReg;

  logic [W:0]      calcMag;
  logic            calcSign;
  logic [BW-1:0]   adj, scrNext;
  logic [W:0]      binNext;
  logic            lastStep;

  // Magnitude/sign of the signed sum; zero never carries a negative sign.
  always_comb begin
    calcMag  = '0;
    calcSign = 1'b0;
    if (sx == sy) begin
      calcMag  = {1'b0, mx} + {1'b0, my};
      calcSign = sx;
    end else if (mx > my) begin
      calcMag  = {1'b0, mx} - {1'b0, my};
      calcSign = sx;
    end else if (my > mx) begin
      calcMag  = {1'b0, my} - {1'b0, mx};
      calcSign = sy;
    end
    if (calcMag == '0) calcSign = 1'b0;
  end

  // One double-dabble step: add-3 to digits >= 5, then shift {scratch, binary} left.
  always_comb begin
    adj = scr;
    for (int d = 0; d < NDIG; d++) begin
      if (scr[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scr[4*d +: 4] + 4'd3;
    end
    scrNext = BW'({adj, bin[W]});
    binNext = {bin[W-1:0], 1'b0};
  end

  assign lastStep = (state == CONV) && (cnt == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.start) stateNext = CALC;
      CALC:    stateNext = CONV;
      CONV:    if (lastStep) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sx      <= 1'b0;
      sy      <= 1'b0;
      mx      <= '0;
      my      <= '0;
      bin     <= '0;
      scr     <= '0;
      cnt     <= '0;
      resMag  <= '0;
      resSign <= 1'b0;
      doneReg <= 1'b0;
      signReg <= 1'b0;
      magReg  <= '0;
      bcdReg  <= '0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          sx <= bus.sign_x;
          sy <= bus.sign_y ^ bus.op;
          mx <= bus.mag_x;
          my <= bus.mag_y;
        end
        CALC: begin
          bin     <= calcMag;
          resMag  <= calcMag;
          resSign <= calcSign;
          scr     <= '0;
          cnt     <= CW'(W + 1);
        end
        CONV: begin
          bin <= binNext;
          scr <= scrNext;
          cnt <= cnt - CW'(1);
          if (lastStep) begin
            doneReg <= 1'b1;
            signReg <= resSign;
            magReg  <= resMag;
            bcdReg  <= scrNext;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = doneReg;
  assign bus.sign_out = signReg;
  assign bus.mag_out  = magReg;
  assign bus.bcd_out  = bcdReg;
endmodule
